// File: rtl/gcd_operand_feeder_pkg.sv
// Shared definitions for the GCD unit and its operand feeder.
package gcd_pkg;

  localparam int GCD_W = 16;

  // Feeder FSM encoding
  typedef logic [1:0] feed_state_t;
  localparam feed_state_t IDLE_S = 2'd0;
  localparam feed_state_t OFFER  = 2'd1;
  localparam feed_state_t BUSY   = 2'd2;
  localparam feed_state_t DRAIN  = 2'd3;

  // Datapath mux selects shared with the GCD controller
  localparam logic [1:0] A_SEL_IN  = 2'd0;
  localparam logic [1:0] A_SEL_B   = 2'd1;
  localparam logic [1:0] A_SEL_SUB = 2'd2;
  localparam logic [1:0] A_SEL_X   = 2'd3;
  localparam logic       B_SEL_IN  = 1'b0;
  localparam logic       B_SEL_A   = 1'b1;

endpackage

// File: rtl/gcd_operand_feeder_if.sv
// Producer-side valid/ready operand pair bus.
interface gcd_operand_feeder_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_A;
  logic [W-1:0] in_B;

  modport master (output in_valid, output in_A, output in_B, input in_ready);
  modport slave  (input in_valid, input in_A, input in_B, output in_ready);
endinterface

// File: rtl/gcd_operand_feeder_fifo.sv
// Small synchronous FIFO holding {A,B} operand pairs.
module gcd_operand_fifo #(
  parameter int WD    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          push,
  input  logic          pop,
  input  logic [WD-1:0] wdata,
  output logic [WD-1:0] rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WD-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage is intentionally not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gcd_operand_feeder.sv
// Feeds buffered operand pairs to the GCD unit one job at a time.
module gcd_operand_feeder
  import gcd_pkg::*;
#(
  parameter int W     = GCD_W,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   reset_,
  gcd_operand_feeder_if.slave    prod,
  output logic [W-1:0]           operand_A,
  output logic [W-1:0]           operand_B,
  output logic                   input_available,
  input  logic                   idle,
  input  logic                   result_rdy,
  output logic [AW:0]            count,
  output logic [15:0]            jobs_issued
);

  feed_state_t   state, state_nx;
  logic          push, pop, full, empty;
  logic [2*W-1:0] head;

  assign prod.in_ready   = !full;
  assign push            = prod.in_valid && !full;
  assign input_available = (state == OFFER);
  // idle is only trusted in OFFER: BUSY/DRAIN mask the GCD's DONE/last-CALC idle.
  assign pop             = (state == OFFER) && idle && !empty;
  assign operand_A       = head[2*W-1:W];
  assign operand_B       = head[W-1:0];

  gcd_operand_fifo #(.WD(2*W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .reset_(reset_),
    .push  (push),
    .pop   (pop),
    .wdata ({prod.in_A, prod.in_B}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Next-state decode for the job sequencer
  always_comb begin
    state_nx = state;
    case (state)
      IDLE_S:  if (!empty)     state_nx = OFFER;
      OFFER:   if (pop)        state_nx = BUSY;
      BUSY:    if (result_rdy) state_nx = DRAIN;
      DRAIN:   if (!result_rdy) state_nx = IDLE_S;
      default:                 state_nx = IDLE_S;
    endcase
  end

  // State register and issued-job counter
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE_S;
      jobs_issued <= '0;
    end else begin
      state <= state_nx;
      if (pop) jobs_issued <= jobs_issued + 16'd1;
    end
  end

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Bench for gcd_operand_feeder with a behavioural GCD unit on the far side.
module tb_gcd_operand_feeder;
  import gcd_pkg::*;

  localparam int W = 16;
  localparam logic [1:0] G_WAIT = 2'd0, G_CALC = 2'd1, G_DONE = 2'd2;

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] g; } job_t;

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  logic idle, result_rdy, input_available;
  logic [W-1:0] operand_A, operand_B;
  logic [2:0] count;
  logic [15:0] jobs_issued;
  logic gcd_en = 1'b1;

  gcd_operand_feeder_if #(.W(W)) bus ();

  gcd_operand_feeder #(.W(W), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset_(reset_), .prod(bus),
    .operand_A(operand_A), .operand_B(operand_B),
    .input_available(input_available), .idle(idle), .result_rdy(result_rdy),
    .count(count), .jobs_issued(jobs_issued)
  );

  always #5 clk = ~clk;

  // Behavioural subtractive GCD unit
  logic [1:0]   g_st;
  logic [W-1:0] ga, gb, result_data;
  assign idle       = gcd_en && (g_st == G_WAIT || g_st == G_DONE || (g_st == G_CALC && gb == '0));
  assign result_rdy = (g_st == G_DONE);

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      g_st <= G_WAIT; ga <= '0; gb <= '0; result_data <= '0;
    end else begin
      case (g_st)
        G_WAIT: if (gcd_en && input_available) begin ga <= operand_A; gb <= operand_B; g_st <= G_CALC; end
        G_CALC: if (gb == '0) begin result_data <= ga; g_st <= G_DONE; end
                else if (ga < gb) begin ga <= gb; gb <= ga; end
                else ga <= ga - gb;
        default: g_st <= G_WAIT;
      endcase
    end
  end

  // Monitor: logs issued pairs and returned results, flags re-issue during result_rdy
  logic [2*W-1:0] iss_arr [64];
  logic [W-1:0]   res_arr [64];
  int n_iss = 0, n_res = 0, dbl_issue = 0;
  always @(negedge clk) begin
    if (reset_) begin
      if (g_st == G_WAIT && gcd_en && input_available) begin
        iss_arr[n_iss[5:0]] <= {operand_A, operand_B}; n_iss <= n_iss + 1;
      end
      if (result_rdy) begin res_arr[n_res[5:0]] <= result_data; n_res <= n_res + 1; end
      if (input_available && result_rdy) dbl_issue <= dbl_issue + 1;
    end
  end

  int vectors = 0, miscompares = 0;
  int rd_iss = 0, rd_res = 0;
  job_t exp_q[$];

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a, y = b, t;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one pair and hold it until accepted; returns at the negedge after the accepting edge.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_A = a; bus.in_B = b;
    while (!bus.in_ready && n < 500) begin @(negedge clk); n++; end
    if (!bus.in_ready) check("push_timeout", 0, 1);
    else begin
      exp_q.push_back('{a: a, b: b, g: ref_gcd(a, b)});
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Wait for all queued jobs to finish, then compare issue order and results.
  task automatic drain_check(input string tag);
    int n = 0;
    int target = exp_q.size();
    job_t j;
    while ((n_res - rd_res) < target && n < 3000) begin @(negedge clk); n++; end
    if ((n_res - rd_res) < target) check({tag, "_timeout"}, n_res - rd_res, target);
    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      j = exp_q.pop_front();
      if (rd_iss < n_iss) check({tag, "_ops"}, iss_arr[rd_iss[5:0]], {j.a, j.b});
      else check({tag, "_missing_issue"}, 0, 1);
      if (rd_res < n_res) check({tag, "_result"}, {16'd0, res_arr[rd_res[5:0]]}, {16'd0, j.g});
      rd_iss++; rd_res++;
    end
  endtask

  initial begin
    logic [15:0] base;
    int n;
    bus.in_valid = 1'b0; bus.in_A = '0; bus.in_B = '0;

    // Reset values
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_avail", input_available, 0);
    check("rst_opA", operand_A, 0);
    check("rst_opB", operand_B, 0);
    check("rst_count", count, 0);
    check("rst_jobs", jobs_issued, 0);
    @(negedge clk); reset_ = 1'b1;
    @(negedge clk);

    // Single job with latency check
    push(16'd36, 16'd15);
    check("lat_avail_k", input_available, 0);
    check("lat_count_k", count, 1);
    @(negedge clk);
    check("lat_avail_k1", input_available, 1);
    check("lat_opA", operand_A, 36);
    @(negedge clk);
    check("lat_avail_drop", input_available, 0);
    check("single_jobs", jobs_issued, 1);
    check("single_count", count, 0);
    drain_check("single");

    // Fill with GCD stalled; fifth pair held until a pop
    gcd_en = 1'b0;
    push(16'd12, 16'd8); push(16'd81, 16'd27); push(16'd7, 16'd5); push(16'd64, 16'd48);
    check("fill_count", count, 4);
    check("fill_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1; bus.in_A = 16'd50; bus.in_B = 16'd20;
    repeat (3) @(negedge clk);
    check("fill_held", count, 4);
    gcd_en = 1'b1;
    push(16'd50, 16'd20);
    drain_check("fill");
    check("fill_jobs", jobs_issued, 6);

    // Ordering
    base = jobs_issued;
    push(16'd36, 16'd15); push(16'd180, 16'd30); push(16'd900, 16'd60);
    drain_check("order");
    check("order_jobs", jobs_issued - base, 3);

    // Simultaneous push and pop at count 2
    gcd_en = 1'b0;
    push(16'd21, 16'd14); push(16'd45, 16'd10);
    check("sim_pre_count", count, 2);
    bus.in_valid = 1'b1; bus.in_A = 16'd99; bus.in_B = 16'd33;
    check("sim_ready", bus.in_ready, 1);
    exp_q.push_back('{a: 16'd99, b: 16'd33, g: ref_gcd(16'd99, 16'd33)});
    gcd_en = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("sim_count", count, 2);
    check("sim_headA", operand_A, 45);
    check("sim_headB", operand_B, 10);
    drain_check("sim");

    // Reset while the GCD is calculating with two entries still queued
    gcd_en = 1'b0;
    push(16'd100, 16'd3); push(16'd20, 16'd8); push(16'd9, 16'd6);
    gcd_en = 1'b1;
    base = jobs_issued;
    n = 0;
    while (jobs_issued == base && n < 50) begin @(negedge clk); n++; end
    check("rb_issued", jobs_issued - base, 1);
    repeat (5) @(negedge clk);
    check("rb_queued", count, 2);
    #2 reset_ = 1'b0;
    #1;
    check("rb_count", count, 0);
    check("rb_avail", input_available, 0);
    check("rb_jobs", jobs_issued, 0);
    check("rb_opA", operand_A, 0);
    check("rb_ready", bus.in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rd_iss = n_iss; rd_res = n_res;
    reset_ = 1'b1;
    @(negedge clk);

    // Zero operand after reset
    push(16'd0, 16'd7);
    drain_check("zero");
    check("zero_jobs", jobs_issued, 1);
    check("zero_state", dut.state, IDLE_S);
    check("zero_avail", input_available, 0);
    check("no_reissue", dbl_issue, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gcd_operand_feeder.md
# gcd_operand_feeder

Upstream feeder for the GCD unit. It buffers operand pairs from a producer on a valid/ready interface in a small FIFO. It presents one pair at a time to the GCD controller/datapath using the `input_available` / `idle` / `result_rdy` signals, and issues the next pair only after the previous job has completed its DONE phase. This replaces the behavioural input model in the test fixture.

## Interface
- `W`, 16, operand width.
- `DEPTH`, 4, FIFO entries; must be a power of 2 and ≥ 2.
- `AW`, 2, pointer width; equals log2(`DEPTH`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has an operand pair.
- `in_ready`  out  1  FIFO can accept a pair.
- `in_A`, `in_B`  in  W  producer operands.
- `operand_A`, `operand_B`  out  W  head-of-FIFO operands to the GCD datapath.
- `input_available`  out  1  head pair offered to the GCD controller.
- `idle`  in  1  GCD controller idle flag.
- `result_rdy`  in  1  GCD controller result-ready flag.
- `count`  out  AW+1  current FIFO occupancy, 0..`DEPTH`.
- `jobs_issued`  out  16  number of pairs handed to the GCD; wraps modulo 2^16.

## Operation
- **Push:** an entry is written at the edge where `in_valid && in_ready` is true. `in_ready = (count != DEPTH)`, decoded from the registered count.
- **Pop:** at the edge that moves the FSM from OFFER to BUSY.
- **Simultaneous push and pop:** `count` is unchanged. Both pointers advance. Pointers wrap modulo `DEPTH`.
- **Operand outputs:** `operand_A` / `operand_B` show the head entry when `count != 0`, and 0 otherwise.
- **FSM:** Moore machine with four states.
  - IDLE_S: move to OFFER if `count != 0`.
  - OFFER: `input_available = 1`. On an edge with `idle == 1`, pop, increment `jobs_issued`, and move to BUSY.
  - BUSY: move to DRAIN when `result_rdy == 1`.
  - DRAIN: move to IDLE_S when `result_rdy == 0`, i.e. the GCD has returned to WAIT.
- **Why BUSY/DRAIN exist:** `idle` is also high in the GCD's DONE state and in its final CALC cycle. BUSY and DRAIN ensure that `idle` is only sampled while the GCD is genuinely in WAIT.
- **No bypass:** a pair pushed into an empty FIFO cannot be offered in the same cycle.
- **Full FIFO:** a push is refused while `count == DEPTH`, even in a cycle that also pops.
- **Arithmetic:** `count` is unsigned with AW+1 bits and never exceeds `DEPTH` or underflows. Operands are passed through unmodified. Zero operands are legal and are forwarded.

## Timing
- **Reset values:** `in_ready = 1`, `input_available = 0`, `operand_A = 0`, `operand_B = 0`, `count = 0`, `jobs_issued = 0`, FSM = IDLE_S, both pointers = 0. FIFO storage is not cleared.
- **Reset mid-operation:** pending entries are discarded and any in-flight job is abandoned. Outputs take their reset values immediately, without waiting for a clock edge.
- **Latency, empty FIFO with FSM in IDLE_S:**
  - push at edge k;
  - OFFER from edge k+1, so `input_available` is high during cycle k+1..k+2;
  - the GCD samples it at edge k+2 and the pair is popped at edge k+2.
- **Back-to-back jobs:** the next OFFER starts 2 edges after `result_rdy` falls (DRAIN → IDLE_S → OFFER).
- `input_available` drops in the cycle after the pop edge. The GCD sees at most one sampled assertion per job.

## Structure
- **Package `gcd_pkg`:** FSM state typedef/encoding (IDLE_S=0, OFFER=1, BUSY=2, DRAIN=3), the default `W` = 16, and the GCD A_sel/B_sel constants so the controller shares them.
- **Sub-module `gcd_operand_fifo`:** synchronous FIFO with a 2W-bit word, pointers, `count`, and full/empty flags.
- **Top level:** the FSM and the job counter.

## Test plan
- **Single job:** push (36,15) into the empty FIFO after reset → `input_available` high one cycle later, pop at the `idle` edge, `result_data` = 3, `jobs_issued` = 1, `count` = 0.
- **Fill:** push 5 pairs back-to-back with no pops (`idle` held low) → 4 accepted, `in_ready` = 0 with `count` = 4, the 5th is held by the producer until a pop, then accepted.
- **Ordering:** queue (36,15), (180,30), (900,60) → GCD results 3, 30, 60 in order, `jobs_issued` = 3, no second issue while `result_rdy` is high.
- **Simultaneous push and pop:** with `count` = 2, push on the pop edge → `count` stays 2, head advances, pointers wrap correctly after 8 total entries.
- **Reset during BUSY:** with 2 entries queued, pulse `reset_` low mid-calculation → `count` = 0, `input_available` = 0, `jobs_issued` = 0 asynchronously. After release with a new push, normal issue resumes.
- **Zero operand:** push (0,7) → issued unchanged, GCD result 7, feeder returns to IDLE_S.
